// File: rtl/apb_switch_pkg.sv
// Shared constants for the APB switch debouncer: register offsets and
// synchroniser depth.
package apb_switch_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    localparam logic [31:0] DATA_OFS    = 32'h0000_0000;
    localparam logic [31:0] RAW_OFS     = 32'h0000_0004;
    localparam logic [31:0] EVENT_OFS   = 32'h0000_0008;
    localparam logic [31:0] IRQ_EN_OFS  = 32'h0000_000C;
    localparam logic [31:0] RISE_EN_OFS = 32'h0000_0010;
    localparam logic [31:0] FALL_EN_OFS = 32'h0000_0014;

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: two-flop synchroniser, hold counter and debounced level.
// rise/fall pulse on the cycle the debounced level is about to change.
module switch_debounce_ch
    import apb_switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   stable_r;
    logic                   accept_s;

    // Metastability filter for the asynchronous switch line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync     = sync_r[SYNC_STAGES-1];
    assign accept_s = (sync != stable_r) && (cnt_r == CNT_LAST);

    // Count consecutive cycles of disagreement; accept the new level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (sync == stable_r) begin
            cnt_r    <= '0;
        end else if (accept_s) begin
            cnt_r    <= '0;
            stable_r <= sync;
        end else begin
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    assign stable = stable_r;
    assign rise   = accept_s & sync;
    assign fall   = accept_s & ~sync;

endmodule

// File: rtl/apb_switch_debounce.sv
// Zero-wait-state APB slave exposing debounced switch levels, sticky W1C edge
// events and a maskable level interrupt.
module apb_switch_debounce
    import apb_switch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0020,
    parameter int          WIDTH           = 32,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    input  logic [WIDTH-1:0] i_switch_value,
    output logic             o_irq
);

    logic [WIDTH-1:0] raw_s, stable_s, rise_s, fall_s;
    logic [WIDTH-1:0] ev_set_s, ev_clr_s;
    logic [WIDTH-1:0] event_r, irq_en_r, rise_en_r, fall_en_r;
    logic [31:0]      data_ext_s, raw_ext_s, event_ext_s;
    logic [31:0]      irq_en_ext_s, rise_en_ext_s, fall_en_ext_s;
    logic             wr_s, rd_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        switch_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk      (PCLK),
            .rst_n    (PRESETn),
            .async_in (i_switch_value[g]),
            .sync     (raw_s[g]),
            .stable   (stable_s[g]),
            .rise     (rise_s[g]),
            .fall     (fall_s[g])
        );
    end

    assign wr_s     = PSEL & PENABLE & PWRITE;
    assign rd_s     = PSEL & PENABLE & ~PWRITE;
    assign ev_set_s = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    assign ev_clr_s = (wr_s && (PADDR == BASE_ADDR + EVENT_OFS)) ? PWDATA[WIDTH-1:0] : '0;

    // Config registers take APB writes; events set after clear so a set wins a collision.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            event_r   <= '0;
            irq_en_r  <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
        end else begin
            event_r <= (event_r & ~ev_clr_s) | ev_set_s;
            if (wr_s) begin
                case (PADDR)
                    BASE_ADDR + IRQ_EN_OFS:  irq_en_r  <= PWDATA[WIDTH-1:0];
                    BASE_ADDR + RISE_EN_OFS: rise_en_r <= PWDATA[WIDTH-1:0];
                    BASE_ADDR + FALL_EN_OFS: fall_en_r <= PWDATA[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Zero-extend channel vectors so bits above WIDTH read as 0.
    always_comb begin
        data_ext_s    = 32'h0;
        raw_ext_s     = 32'h0;
        event_ext_s   = 32'h0;
        irq_en_ext_s  = 32'h0;
        rise_en_ext_s = 32'h0;
        fall_en_ext_s = 32'h0;
        data_ext_s[WIDTH-1:0]    = stable_s;
        raw_ext_s[WIDTH-1:0]     = raw_s;
        event_ext_s[WIDTH-1:0]   = event_r;
        irq_en_ext_s[WIDTH-1:0]  = irq_en_r;
        rise_en_ext_s[WIDTH-1:0] = rise_en_r;
        fall_en_ext_s[WIDTH-1:0] = fall_en_r;
    end

    // Read mux, driven only during a read access phase.
    always_comb begin
        PRDATA = 32'h0;
        if (rd_s) begin
            case (PADDR)
                BASE_ADDR + DATA_OFS:    PRDATA = data_ext_s;
                BASE_ADDR + RAW_OFS:     PRDATA = raw_ext_s;
                BASE_ADDR + EVENT_OFS:   PRDATA = event_ext_s;
                BASE_ADDR + IRQ_EN_OFS:  PRDATA = irq_en_ext_s;
                BASE_ADDR + RISE_EN_OFS: PRDATA = rise_en_ext_s;
                BASE_ADDR + FALL_EN_OFS: PRDATA = fall_en_ext_s;
                default:                 PRDATA = 32'h0;
            endcase
        end else begin
            PRDATA = 32'h0;
        end
    end

    assign PREADY = 1'b1;
    assign o_irq  = |(event_r & irq_en_r);

endmodule

// File: doc/apb_switch_debounce.md
# apb_switch_debounce

Parametrised APB slave that samples WIDTH hardware switch/button lines and synchronises and debounces each one. It records rising/falling edge events in sticky write-1-to-clear registers and raises a maskable level interrupt. It replaces the plain single-register switch reader on the APB peripheral bus of the RISC-V SoC and keeps the same zero-wait-state APB behaviour.

## Interface
- BASE_ADDR, 32'h20: byte address of register 0; registers at BASE_ADDR + offset.
- WIDTH, 32: number of switch channels, 1..32; register bits above WIDTH read 0.
- DEBOUNCE_CYCLES, 16: consecutive PCLK cycles a changed input must hold before it is accepted; ≥1.
- PCLK  in  1  clock; all state on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- i_switch_value  in  WIDTH  asynchronous raw switch levels.
- o_irq  out  1  level interrupt, active-high.

## Operation
- Register map (offset, access): 0x00 DATA RO debounced levels; 0x04 RAW RO synchronised, undebounced levels; 0x08 EVENT W1C sticky edge flags; 0x0C IRQ_EN RW per-channel interrupt enable; 0x10 RISE_EN RW; 0x14 FALL_EN RW.
- Address decode: full 32-bit compare of PADDR with BASE_ADDR + offset. Unmapped reads return 0. Unmapped writes and writes to RO registers are ignored.
- Write strobe: PSEL & PENABLE & PWRITE. Read: PSEL & PENABLE & !PWRITE. PRDATA is combinational and is the selected register during a read access phase, otherwise 32'h0.
- Per channel: 2-flop synchroniser gives sync. The stable register holds the debounced level. A counter of width $clog2(DEBOUNCE_CYCLES+1) clears whenever sync == stable and increments while sync != stable. When the counter reaches DEBOUNCE_CYCLES - 1 with sync still != stable, stable <= sync and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
- Edge event: on the cycle stable changes 0→1 with RISE_EN[i]=1, or 1→0 with FALL_EN[i]=1, EVENT[i] <= 1.
- EVENT W1C: a write clears bits where PWDATA[i]=1. If a set and a clear hit the same bit in the same cycle, the set wins.
- o_irq = |(EVENT & IRQ_EN), combinational from flops only.
- Reset (PRESETn low, any time, including mid-debounce or mid-transfer): synchronisers, stable, counters, EVENT, IRQ_EN, RISE_EN and FALL_EN all clear to 0. o_irq = 0. PRDATA = 0. PREADY = 1.
- Switches already high at reset release produce a rising event after debounce, if RISE_EN is set by then.

## Timing
- Zero wait states: PREADY is always 1 and every transfer completes in its access phase.
- Register writes take effect on the PCLK edge ending the access phase and are visible to the next transfer.
- Input to RAW: 2 cycles. Input to DATA/EVENT: 2 + DEBOUNCE_CYCLES cycles after the edge where i_switch_value changed, for a clean step.
- EVENT to o_irq: 0 cycles (same cycle EVENT/IRQ_EN update is visible).
- A read of EVENT in the same access phase as an edge event returns the pre-update value.

## Structure
- Package apb_switch_pkg: register offset localparams (DATA_OFS … FALL_EN_OFS) and the sync stage count (2).
- Sub-module switch_debounce_ch: one channel's synchroniser, counter and stable register. Outputs are stable, rise pulse and fall pulse. It is instantiated WIDTH times via generate.
- Top level holds APB decode, the config/event registers and the irq reduction.

## Test plan
- Reset: assert PRESETn=0 mid-debounce with the inputs toggling -> all outputs 0, PREADY=1; after release, reads of every register return 0 except DATA/RAW reflecting the inputs once settled.
- Debounce (WIDTH=8, DEBOUNCE_CYCLES=4): i_switch_value 8'h00→8'h05 held -> RAW=0x05 after 2 cycles, DATA=0x05 after 6. A 3-cycle pulse on bit 7 -> DATA bit 7 stays 0.
- Events/IRQ: RISE_EN=0xFF, IRQ_EN=0x01, bit 0 rises -> EVENT=0x01 and o_irq=1. Write EVENT=0x01 -> EVENT=0, o_irq=0. A fall on bit 0 with FALL_EN=0 -> no event.
- Set/clear collision: W1C of bit 2 in the same cycle that bit 2's rise is accepted -> EVENT bit 2 = 1.
- Decode: read BASE_ADDR+0x18 -> 0. Write 0xFFFF_FFFF to DATA -> DATA unchanged. Write IRQ_EN=0xFFFF_FFFF with WIDTH=8 -> reads 0x0000_00FF.
- Protocol: PSEL=1, PENABLE=0 with PWRITE=1 -> no register change. Read outside the access phase -> PRDATA=0.
